fir_filter_param: RTL and testbench

Parametrised direct-form FIR filter that replaces the fixed 4-tap, free-running moving-average filter in the evaluation flow. Adds configurable tap count and widths, a runtime coefficient write port, a valid-qualified sample stream, a 2-stage pipeline, selectable saturation or wrap on the output, and a synchronous flush. It sits between the test-signal source and the result monitor. Its default coefficients reproduce the existing moving-average target.

---
 rtl/fir_pkg.sv | 31 +++
 rtl/fir_sat_shift.sv | 39 +++
 rtl/fir_filter_param.sv | 121 ++++++++++++
 tb/tb_fir_filter_param.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared helpers and default widths for the parametrised FIR filter.
`timescale 1ns/1ps

package fir_pkg;

    // Ceiling log2, never below 1 so that a tap index always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

    // Default configuration (moving-average replacement).
    localparam int DEF_NTAPS  = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_COEF_W = 8;
    localparam int DEF_OUT_W  = 16;

    // Full-precision product and accumulator widths for the default configuration.
    localparam int PROD_W = DEF_DATA_W + DEF_COEF_W;
    localparam int ACC_W  = PROD_W + clog2(DEF_NTAPS);

    typedef logic signed [DEF_DATA_W-1:0] sample_t;
    typedef logic signed [DEF_COEF_W-1:0] coef_t;
    typedef logic signed [PROD_W-1:0]     prod_t;
    typedef logic signed [ACC_W-1:0]      acc_t;

endpackage

// File: rtl/fir_sat_shift.sv
// Output conditioning: arithmetic right shift, then saturate or wrap to OUT_W bits.
`timescale 1ns/1ps

module fir_sat_shift
    import fir_pkg::*;
#(
    parameter int IN_W      = ACC_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int OUT_SHIFT = 0,
    parameter int SAT       = 1
) (
    input  logic signed [IN_W-1:0]  acc,
    output logic signed [OUT_W-1:0] result
);

    // One guard bit above the wider of the two widths keeps the range compare exact.
    localparam int EXT_W = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;
    localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0]  shifted;
    logic signed [EXT_W-1:0] wide;

    // Shift, sign-extend, then clamp to the signed output range or keep the low bits.
    always_comb begin
        // NOTE: result gets its wrap value first so every path assigns it and no latch is inferred.
        shifted = acc >>> OUT_SHIFT;
        wide    = {{(EXT_W-IN_W){shifted[IN_W-1]}}, shifted};
        result  = wide[OUT_W-1:0];
        if (SAT != 0) begin
            if (wide > MAX_V) begin
                result = MAX_V[OUT_W-1:0];
            end else if (wide < MIN_V) begin
                result = MIN_V[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fir_filter_param.sv
// Direct-form FIR: valid-qualified delay line, registered products, registered sum.
`timescale 1ns/1ps

module fir_filter_param
    import fir_pkg::*;
#(
    parameter int                NTAPS     = DEF_NTAPS,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                COEF_W    = DEF_COEF_W,
    parameter int                OUT_W     = DEF_OUT_W,
    parameter int                OUT_SHIFT = 0,
    parameter int                SAT       = 1,
    parameter logic [COEF_W-1:0] COEF_RST  = 8'h20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   data_in,
    input  logic                       flush,
    input  logic                       coef_we,
    input  logic [clog2(NTAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic                       out_valid,
    output logic signed [OUT_W-1:0]    data_out
);

    localparam int PRODUCT_W = DATA_W + COEF_W;
    localparam int SUM_W     = PRODUCT_W + clog2(NTAPS);

    logic signed [DATA_W-1:0]    x    [NTAPS];
    logic signed [COEF_W-1:0]    c    [NTAPS];
    logic signed [PRODUCT_W-1:0] p    [NTAPS];
    logic signed [SUM_W-1:0]     sum;
    logic signed [OUT_W-1:0]     conditioned;
    logic                        accept;
    logic                        v0;
    logic                        v1;

    assign accept = in_valid & ~flush;

    // Delay line: shifts only on an accepted sample, cleared by flush.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use <= so every stage samples the pre-edge values of the others.
        if (reset) begin
            for (int k = 0; k < NTAPS; k++) x[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < NTAPS; k++) x[k] <= '0;
        end else if (in_valid) begin
            x[0] <= data_in;
            for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
        end
    end

    // Coefficient bank: runtime writes, out-of-range addresses ignored, kept across flush.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the bank is a small flop array with a defined reset value, not a RAM, so resetting it is intended.
        if (reset) begin
            for (int k = 0; k < NTAPS; k++) c[k] <= COEF_RST;
        end else if (coef_we && (int'(coef_addr) < NTAPS)) begin
            c[coef_addr] <= coef_data;
        end
    end

    // Marks that the delay line holds a freshly accepted sample for stage 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0 <= 1'b0;
        end else begin
            v0 <= accept;
        end
    end

    // Stage 1: products latch only when a sample advances, flush discards the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NTAPS; k++) p[k] <= '0;
            v1 <= 1'b0;
        end else if (flush) begin
            v1 <= 1'b0;
        end else begin
            v1 <= v0;
            if (v0) begin
                for (int k = 0; k < NTAPS; k++) begin
                    p[k] <= PRODUCT_W'(x[k]) * PRODUCT_W'(c[k]);
                end
            end
        end
    end

    // Exact full-width adder tree over the sign-extended products.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NTAPS; k++) begin
            sum = sum + {{(SUM_W-PRODUCT_W){p[k][PRODUCT_W-1]}}, p[k]};
        end
    end

    fir_sat_shift #(
        .IN_W      (SUM_W),
        .OUT_W     (OUT_W),
        .OUT_SHIFT (OUT_SHIFT),
        .SAT       (SAT)
    ) u_sat_shift (
        .acc    (sum),
        .result (conditioned)
    );

    // Stage 2: register the conditioned sum; data_out holds when no result is produced.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                data_out <= conditioned;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter_param.sv
// Self-checking bench: saturating and wrapping instances against a sample-history model.
`timescale 1ns/1ps

module tb_fir_filter_param;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [7:0]        data_in;
    logic              flush;
    logic              coef_we;
    logic [1:0]        coef_addr;
    logic [7:0]        coef_data;
    logic              ov_s;
    logic              ov_w;
    logic signed [15:0] do_s;
    logic signed [15:0] do_w;
    logic signed [17:0] ut_acc;
    logic signed [7:0]  ut_sat;
    logic signed [7:0]  ut_wrap;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int due;
        int sat_v;
        int wrap_v;
    } exp_t;

    int   edge_no;
    int   hist   [4];
    int   coef_m [4];
    exp_t pend   [$];
    int   last_sat;
    int   last_wrap;

    fir_filter_param #(.SAT(1)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov_s), .data_out(do_s)
    );

    fir_filter_param #(.SAT(0)) dut_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov_w), .data_out(do_w)
    );

    fir_sat_shift #(.IN_W(18), .OUT_W(8), .OUT_SHIFT(2), .SAT(1)) ut_s (.acc(ut_acc), .result(ut_sat));
    fir_sat_shift #(.IN_W(18), .OUT_W(8), .OUT_SHIFT(2), .SAT(0)) ut_w (.acc(ut_acc), .result(ut_wrap));

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wrap_to(input longint v, input int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = ((v % m) + m) % m;
        if (r >= m / 2) r = r - m;
        return int'(r);
    endfunction

    function automatic int sat_to(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        if (v > hi) return int'(hi);
        if (v < lo) return int'(lo);
        return int'(v);
    endfunction

    task automatic check(input string tag, input logic signed [31:0] got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            hist[k]   = 0;
            coef_m[k] = 32;
        end
        pend.delete();
        last_sat  = 0;
        last_wrap = 0;
    endtask

    // One clock: drive inputs, advance the model for that edge, then compare.
    task automatic step(input bit iv, input int d, input bit fl, input bit we, input int addr, input int cd);
        bit   exp_v;
        int   s;
        exp_t e;
        in_valid  = iv;
        data_in   = d[7:0];
        flush     = fl;
        coef_we   = we;
        coef_addr = addr[1:0];
        coef_data = cd[7:0];
        @(posedge clk);
        edge_no++;
        exp_v = 1'b0;
        if (pend.size() > 0 && pend[0].due == edge_no) begin
            exp_v     = 1'b1;
            last_sat  = pend[0].sat_v;
            last_wrap = pend[0].wrap_v;
            pend.delete(0);
        end
        if (we) coef_m[addr] = cd;
        if (fl) begin
            for (int k = 0; k < 4; k++) hist[k] = 0;
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].due == edge_no + 1) pend.delete(i);
            end
        end else if (iv) begin
            for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = d;
            s = 0;
            for (int k = 0; k < 4; k++) s = s + hist[k] * coef_m[k];
            e.due    = edge_no + 2;
            e.sat_v  = sat_to(s, 16);
            e.wrap_v = wrap_to(s, 16);
            pend.push_back(e);
        end
        #1;
        check($sformatf("out_valid_sat@%0d", edge_no), ov_s, exp_v);
        check($sformatf("out_valid_wrap@%0d", edge_no), ov_w, exp_v);
        check($sformatf("data_out_sat@%0d", edge_no), do_s, last_sat);
        check($sformatf("data_out_wrap@%0d", edge_no), do_w, last_wrap);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic write_all(input int cd);
        for (int a = 0; a < 4; a++) step(0, 0, 0, 1, a, cd);
    endtask

    initial begin
        longint uv [11];
        longint v;
        longint sh;

        reset     = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        flush     = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        ut_acc    = '0;
        edge_no   = 0;
        model_reset();

        // Output conditioning unit: shift by 2, 8-bit result, boundary and random values.
        uv = '{0, 511, 512, 513, -512, -513, -516, 131071, -131072, 1000, -1000};
        for (int i = 0; i < 21; i++) begin
            v = (i < 11) ? uv[i] : longint'($urandom_range(0, 262143)) - 131072;
            ut_acc = v[17:0];
            #1;
            sh = v >>> 2;
            check($sformatf("unit_sat[%0d]", v), ut_sat, sat_to(sh, 8));
            check($sformatf("unit_wrap[%0d]", v), ut_wrap, wrap_to(sh, 8));
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", ov_s, 0);
        check("reset_data_out", do_s, 0);
        check("reset_data_out_wrap", do_w, 0);
        @(negedge clk);
        reset = 1'b0;

        // Moving average with four samples of 10.
        for (int i = 0; i < 4; i++) step(1, 10, 0, 0, 0, 0);
        idle(2);
        check("avg_final", do_s, 1280);

        // Gapped input: the line holds during gaps.
        step(0, 0, 1, 0, 0, 0);
        step(1, 10, 0, 0, 0, 0);
        idle(2);
        check("gap_first", do_s, 320);
        step(1, 20, 0, 0, 0, 0);
        idle(2);
        check("gap_second", do_s, 960);

        // Overflow: positive extreme.
        write_all(127);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 127, 0, 0, 0, 0);
        idle(2);
        check("pos_sat", do_s, 32767);
        check("pos_wrap", do_w, -1020);

        // Overflow: negative extreme times negative extreme.
        write_all(-128);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, -128, 0, 0, 0, 0);
        idle(2);
        check("neg_sat", do_s, 32767);
        check("neg_wrap", do_w, 0);

        // Coefficient written on the same edge as the sample that uses it.
        for (int a = 1; a < 4; a++) step(0, 0, 0, 1, a, 0);
        step(0, 0, 1, 0, 0, 0);
        step(1, 5, 0, 1, 0, 1);
        step(1, 7, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("coef_same_edge", do_s, 5);
        step(0, 0, 0, 0, 0, 0);
        check("coef_next_sample", do_s, 7);

        // Flush overrides a concurrent sample and clears the history.
        write_all(32);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 10, 0, 0, 0, 0);
        idle(2);
        step(1, 99, 1, 0, 0, 0);
        step(1, 4, 0, 0, 0, 0);
        idle(2);
        check("flush_next", do_s, 128);

        // Flush one edge after an accept discards that result.
        step(1, 50, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle(3);

        // Randomised traffic with coefficient writes and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            int r_d;
            int r_c;
            r_d = int'($urandom_range(0, 255)) - 128;
            r_c = int'($urandom_range(0, 255)) - 128;
            step(($urandom_range(0, 9) < 7), r_d, ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)), r_c);
        end
        idle(3);

        // Asynchronous reset with results in flight.
        step(1, 30, 0, 0, 0, 0);
        step(1, 40, 0, 0, 0, 0);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        flush    = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_out_valid", ov_s, 0);
        check("async_rst_data_out", do_s, 0);
        check("async_rst_out_valid_wrap", ov_w, 0);
        check("async_rst_data_out_wrap", do_w, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(1, 50, 0, 0, 0, 0);
        idle(2);
        check("post_reset_first", do_s, 1600);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
